// File: rtl/fetch_sequencer_if.sv
// Control bundle between the fetch sequencer, the instruction unit strobes
// and the execute-stage issue handshake.
interface fetch_sequencer_if;
  logic [31:0] IR_out;
  logic        ex_ready;
  logic        ex_done;
  logic        ex_taken;
  logic        im_cs;
  logic        im_rd;
  logic        im_wr;
  logic        pc_inc;
  logic        pc_ld;
  logic        ir_ld;
  logic [1:0]  pc_sel;
  logic        issue_valid;
  logic        halted;
  logic        ex_timeout;
  logic [31:0] instr_count;

  // Sequencer side
  modport master (
    input  IR_out, ex_ready, ex_done, ex_taken,
    output im_cs, im_rd, im_wr, pc_inc, pc_ld, ir_ld, pc_sel,
           issue_valid, halted, ex_timeout, instr_count
  );

  // Instruction unit / execute side
  modport slave (
    output IR_out, ex_ready, ex_done, ex_taken,
    input  im_cs, im_rd, im_wr, pc_inc, pc_ld, ir_ld, pc_sel,
           issue_valid, halted, ex_timeout, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/decode/issue sequencer: drives instruction-unit strobes,
// issues to execute, resolves control flow after execute and halts on break.
module fetch_sequencer #(
  parameter int unsigned IM_WAIT  = 0,
  parameter int unsigned WD_LIMIT = 255
) (
  input logic              CLK,
  input logic              RESET,
  fetch_sequencer_if.master bus
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned WD_W   = 16;
  localparam int unsigned CNT_W  = 32;

  localparam logic [2:0] S_START    = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_IR_LOAD  = 3'd2;
  localparam logic [2:0] S_DECODE   = 3'd3;
  localparam logic [2:0] S_ISSUE    = 3'd4;
  localparam logic [2:0] S_WAIT_EX  = 3'd5;
  localparam logic [2:0] S_REDIRECT = 3'd6;
  localparam logic [2:0] S_HALT     = 3'd7;

  localparam logic [1:0] CLS_PLAIN = 2'd0;
  localparam logic [1:0] CLS_BR    = 2'd1;
  localparam logic [1:0] CLS_JAL   = 2'd2;
  localparam logic [1:0] CLS_JR    = 2'd3;

  localparam logic [1:0] SEL_BRANCH = 2'd0;
  localparam logic [1:0] SEL_JUMP   = 2'd1;
  localparam logic [1:0] SEL_REG    = 2'd2;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_BREAK   = 6'h0D;

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [1:0]        cls_q, cls_d;
  logic [1:0]        pc_sel_q, pc_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;

  logic im_cs_c, im_rd_c, pc_inc_c, pc_ld_c, ir_ld_c, issue_valid_c, halted_c;

  logic [5:0] op, funct;
  logic       unused_ir;

  assign op        = bus.IR_out[31:26];
  assign funct     = bus.IR_out[5:0];
  assign unused_ir = ^bus.IR_out[25:6];

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_START;
      wait_q   <= '0;
      wd_q     <= '0;
      cls_q    <= CLS_PLAIN;
      pc_sel_q <= SEL_BRANCH;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      wd_q     <= wd_d;
      cls_q    <= cls_d;
      pc_sel_q <= pc_sel_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state logic and Moore output decode
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    wd_d          = wd_q;
    cls_d         = cls_q;
    pc_sel_d      = pc_sel_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    im_cs_c       = 1'b0;
    im_rd_c       = 1'b0;
    pc_inc_c      = 1'b0;
    pc_ld_c       = 1'b0;
    ir_ld_c       = 1'b0;
    issue_valid_c = 1'b0;
    halted_c      = 1'b0;

    case (state_q)
      S_START: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        im_cs_c = 1'b1;
        im_rd_c = 1'b1;
        if (wait_q == WAIT_W'(IM_WAIT)) begin
          wait_d  = '0;
          state_d = S_IR_LOAD;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_IR_LOAD: begin
        im_cs_c  = 1'b1;
        im_rd_c  = 1'b1;
        ir_ld_c  = 1'b1;
        pc_inc_c = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_ISSUE;
        cls_d   = CLS_PLAIN;
        case (op)
          OP_J: begin
            pc_sel_d = SEL_JUMP;
            cnt_d    = cnt_q + CNT_W'(1);
            state_d  = S_REDIRECT;
          end
          OP_SPECIAL: begin
            if (funct == FN_BREAK) begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = S_HALT;
            end else if (funct == FN_JR) begin
              cls_d = CLS_JR;
            end
          end
          OP_JAL:         cls_d = CLS_JAL;
          OP_BEQ, OP_BNE: cls_d = CLS_BR;
          default:        cls_d = CLS_PLAIN;
        endcase
      end
      S_ISSUE: begin
        issue_valid_c = 1'b1;
        if (bus.ex_ready) begin
          wd_d    = '0;
          state_d = S_WAIT_EX;
        end
      end
      S_WAIT_EX: begin
        // Completion takes priority over a watchdog expiring on the same cycle
        if (bus.ex_done) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_FETCH;
          case (cls_q)
            CLS_BR: begin
              if (bus.ex_taken) begin
                pc_sel_d = SEL_BRANCH;
                state_d  = S_REDIRECT;
              end
            end
            CLS_JAL: begin
              pc_sel_d = SEL_JUMP;
              state_d  = S_REDIRECT;
            end
            CLS_JR: begin
              pc_sel_d = SEL_REG;
              state_d  = S_REDIRECT;
            end
            default: state_d = S_FETCH;
          endcase
        end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_REDIRECT: begin
        pc_ld_c = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: state_d = S_START;
    endcase
  end

  assign bus.im_cs       = im_cs_c;
  assign bus.im_rd       = im_rd_c;
  assign bus.im_wr       = 1'b0;
  assign bus.pc_inc      = pc_inc_c;
  assign bus.pc_ld       = pc_ld_c;
  assign bus.ir_ld       = ir_ld_c;
  assign bus.pc_sel      = pc_sel_q;
  assign bus.issue_valid = issue_valid_c;
  assign bus.halted      = halted_c;
  assign bus.ex_timeout  = tmo_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed instruction vectors push
// expected strobe events; a negedge monitor pops and compares them.
module tb_fetch_sequencer;

  localparam logic [2:0] K_IRLD  = 3'd1;
  localparam logic [2:0] K_ISSUE = 3'd2;
  localparam logic [2:0] K_REDIR = 3'd3;
  localparam logic [2:0] K_HALT  = 3'd4;

  localparam int W_IRLD  = 0;
  localparam int W_ISSUE = 1;
  localparam int W_PCLD  = 2;
  localparam int W_HALT  = 3;

  typedef struct packed {
    logic [2:0]  kind;
    logic [1:0]  sel;
    logic        aux;
    logic        tmo;
    logic [31:0] cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;
  ev_t  exp_q[$];
  logic prev_halted = 1'b0;

  fetch_sequencer_if bus_a ();
  fetch_sequencer_if bus_b ();

  fetch_sequencer #(.IM_WAIT(0), .WD_LIMIT(4)) u_dut (
    .CLK(clk), .RESET(rst_n), .bus(bus_a)
  );

  fetch_sequencer #(.IM_WAIT(3), .WD_LIMIT(255)) u_dut_w3 (
    .CLK(clk), .RESET(rst_n), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_ev(input ev_t a, input ev_t e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL event: got kind=%0d sel=%0d aux=%0b tmo=%0b cnt=%0d, expected kind=%0d sel=%0d aux=%0b tmo=%0b cnt=%0d",
                  a.kind, a.sel, a.aux, a.tmo, a.cnt, e.kind, e.sel, e.aux, e.tmo, e.cnt);
  endtask

  task automatic push(input logic [2:0] kind, input logic [1:0] sel, input logic tmo, input int cnt);
    ev_t e;
    e.kind = kind;
    e.sel  = sel;
    e.aux  = 1'b1;
    e.tmo  = tmo;
    e.cnt  = 32'(cnt);
    exp_q.push_back(e);
  endtask

  function automatic logic [10:0] outs_a();
    return {bus_a.im_cs, bus_a.im_rd, bus_a.im_wr, bus_a.pc_inc, bus_a.pc_ld, bus_a.ir_ld,
            bus_a.pc_sel, bus_a.issue_valid, bus_a.halted, bus_a.ex_timeout};
  endfunction

  function automatic logic [4:0] fetch_vec();
    return {bus_a.im_cs, bus_a.im_rd, bus_a.ir_ld, bus_a.pc_inc, bus_a.issue_valid};
  endfunction

  // Waits (bounded) for a strobe to be seen at a falling edge
  task automatic wait_until(input int which, input string name);
    logic hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      case (which)
        W_IRLD:  hit = bus_a.ir_ld;
        W_ISSUE: hit = bus_a.issue_valid;
        W_PCLD:  hit = bus_a.pc_ld;
        default: hit = bus_a.halted;
      endcase
    end
    if (!hit) begin
      n_total++;
      $display("FAIL timeout %s: strobe not seen, expected within 60 cycles", name);
    end
  endtask

  // From an ISSUE cycle with ex_ready high: transfer, then ex_done on the 2nd WAIT_EX cycle
  task automatic do_ex(input logic taken);
    @(posedge clk);
    @(posedge clk);
    #1 bus_a.ex_done = 1'b1; bus_a.ex_taken = taken;
    @(posedge clk);
    #1 bus_a.ex_done = 1'b0; bus_a.ex_taken = 1'b0;
  endtask

  task automatic assert_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check(name, 64'({outs_a(), bus_a.instr_count}), 64'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    ev_t  act;
    logic have;
    have = 1'b0;
    act  = '0;
    if (rst_n) begin
      act.tmo = bus_a.ex_timeout;
      act.cnt = bus_a.instr_count;
      if (bus_a.ir_ld) begin
        act.kind = K_IRLD;
        act.aux  = bus_a.pc_inc & bus_a.im_cs & bus_a.im_rd & ~bus_a.pc_ld;
        have = 1'b1;
      end else if (bus_a.issue_valid && bus_a.ex_ready) begin
        act.kind = K_ISSUE;
        act.aux  = ~(bus_a.im_cs | bus_a.pc_ld | bus_a.pc_inc);
        have = 1'b1;
      end else if (bus_a.pc_ld) begin
        act.kind = K_REDIR;
        act.sel  = bus_a.pc_sel;
        act.aux  = ~(bus_a.pc_inc | bus_a.im_cs | bus_a.issue_valid);
        have = 1'b1;
      end else if (bus_a.halted && !prev_halted) begin
        act.kind = K_HALT;
        act.aux  = ~(bus_a.im_cs | bus_a.im_rd | bus_a.im_wr | bus_a.pc_inc | bus_a.pc_ld |
                     bus_a.ir_ld | bus_a.issue_valid);
        have = 1'b1;
      end
      if (have) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected event: got kind=%0d cnt=%0d, expected no event", act.kind, act.cnt);
        end else begin
          check_ev(act, exp_q.pop_front());
        end
      end
    end
    prev_halted <= bus_a.halted;
  end

  // IM_WAIT = 3 instance: FETCH must hold im_cs/im_rd for 4 cycles before IR load
  initial begin
    int n = 0;
    logic done = 1'b0;
    @(posedge rst_n);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus_b.im_cs && bus_b.im_rd && !bus_b.ir_ld) n++;
      else if (n > 0) done = 1'b1;
    end
    check("w3_fetch_cycles", 64'(n), 64'd4);
    check("w3_ir_load", 64'({bus_b.ir_ld, bus_b.pc_inc}), 64'(2'b11));
  end

  initial begin
    rst_n = 1'b0;
    bus_a.IR_out = 32'h0000_0020; bus_a.ex_ready = 1'b1; bus_a.ex_done = 1'b0; bus_a.ex_taken = 1'b0;
    bus_b.IR_out = 32'h0000_0020; bus_b.ex_ready = 1'b0; bus_b.ex_done = 1'b0; bus_b.ex_taken = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(outs_a()), 64'd0);
    check("reset_count", 64'(bus_a.instr_count), 64'd0);

    // add: START, FETCH, IR_LOAD, DECODE, ISSUE, WAIT_EX, FETCH
    push(K_IRLD, 2'd0, 1'b0, 0);
    push(K_ISSUE, 2'd0, 1'b0, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("start", 64'(outs_a()), 64'd0);
    @(negedge clk) check("fetch", 64'(fetch_vec()), 64'(5'b11000));
    @(negedge clk) check("ir_load", 64'(fetch_vec()), 64'(5'b11110));
    @(negedge clk) check("decode", 64'(fetch_vec()), 64'(5'b00000));
    @(negedge clk) check("issue", 64'(fetch_vec()), 64'(5'b00001));
    do_ex(1'b0);
    @(negedge clk) check("add_done", 64'({bus_a.im_cs, bus_a.pc_ld, bus_a.instr_count}), 64'({2'b10, 32'd1}));

    // j: DECODE -> REDIRECT sel 1, no issue
    bus_a.IR_out = 32'h0800_0040;
    push(K_IRLD, 2'd0, 1'b0, 1);
    push(K_REDIR, 2'd1, 1'b0, 2);
    wait_until(W_PCLD, "j_redirect");
    @(negedge clk) check("j_then_fetch", 64'({bus_a.im_cs, bus_a.pc_ld, bus_a.issue_valid}), 64'(3'b100));

    // beq taken then not taken
    bus_a.IR_out = 32'h1000_FFFF;
    push(K_IRLD, 2'd0, 1'b0, 2);
    push(K_ISSUE, 2'd0, 1'b0, 2);
    push(K_REDIR, 2'd0, 1'b0, 3);
    wait_until(W_ISSUE, "beq_t_issue");
    do_ex(1'b1);
    wait_until(W_PCLD, "beq_t_redirect");
    push(K_IRLD, 2'd0, 1'b0, 3);
    push(K_ISSUE, 2'd0, 1'b0, 3);
    wait_until(W_ISSUE, "beq_nt_issue");
    do_ex(1'b0);
    @(negedge clk) check("beq_nt_fetch", 64'({bus_a.im_cs, bus_a.pc_ld, bus_a.instr_count}), 64'({2'b10, 32'd4}));

    // ISSUE stall: ex_ready low 5 edges, ex_done pulses ignored
    bus_a.ex_ready = 1'b0;
    bus_a.IR_out = 32'h0000_0020;
    push(K_IRLD, 2'd0, 1'b0, 4);
    push(K_ISSUE, 2'd0, 1'b0, 4);
    wait_until(W_ISSUE, "stall_issue");
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'({bus_a.issue_valid, bus_a.im_cs}), 64'(2'b10));
      @(posedge clk);
      #1 bus_a.ex_done = (i % 2 == 0);
      @(negedge clk);
    end
    bus_a.ex_ready = 1'b1;
    bus_a.ex_done  = 1'b0;
    do_ex(1'b0);
    @(negedge clk) check("stall_done", 64'({bus_a.im_cs, bus_a.instr_count}), 64'({1'b1, 32'd5}));

    // watchdog: 4 WAIT_EX cycles without ex_done
    push(K_IRLD, 2'd0, 1'b0, 5);
    push(K_ISSUE, 2'd0, 1'b0, 5);
    push(K_HALT, 2'd0, 1'b1, 5);
    wait_until(W_ISSUE, "wd_issue");
    @(posedge clk);
    begin
      int n = 0;
      logic seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (bus_a.halted) seen = 1'b1;
        else n++;
      end
      check("wd_cycles", 64'(n), 64'd4);
    end
    check("wd_halt_outputs", 64'(outs_a()), 64'(11'b00000000011));
    @(posedge clk); #1 bus_a.ex_done = 1'b1;
    @(posedge clk); #1 bus_a.ex_done = 1'b0;
    repeat (4) @(negedge clk);
    check("wd_absorbing", 64'({bus_a.halted, bus_a.ex_timeout, bus_a.im_cs, bus_a.instr_count}), 64'({3'b110, 32'd5}));

    // break: reset from HALT, then DECODE -> HALT
    bus_a.IR_out = 32'h0000_000D;
    assert_reset("reset_from_wd_halt");
    push(K_IRLD, 2'd0, 1'b0, 0);
    push(K_HALT, 2'd0, 1'b0, 1);
    @(negedge clk) rst_n = 1'b1;
    wait_until(W_HALT, "break_halt");
    repeat (3) @(negedge clk);
    check("break_absorbing", 64'({bus_a.halted, bus_a.ex_timeout, bus_a.issue_valid, bus_a.instr_count}), 64'({3'b100, 32'd1}));

    // jal -> REDIRECT sel 1, jr -> REDIRECT sel 2
    bus_a.IR_out = 32'h0C00_0000;
    assert_reset("reset_from_break_halt");
    push(K_IRLD, 2'd0, 1'b0, 0);
    push(K_ISSUE, 2'd0, 1'b0, 0);
    push(K_REDIR, 2'd1, 1'b0, 1);
    @(negedge clk) rst_n = 1'b1;
    wait_until(W_ISSUE, "jal_issue");
    do_ex(1'b0);
    wait_until(W_PCLD, "jal_redirect");
    bus_a.IR_out = 32'h03E0_0008;
    push(K_IRLD, 2'd0, 1'b0, 1);
    push(K_ISSUE, 2'd0, 1'b0, 1);
    push(K_REDIR, 2'd2, 1'b0, 2);
    wait_until(W_ISSUE, "jr_issue");
    do_ex(1'b0);
    wait_until(W_PCLD, "jr_redirect");

    // undefined opcode behaves as plain; ex_taken has no effect
    bus_a.IR_out = 32'hFC00_0000;
    push(K_IRLD, 2'd0, 1'b0, 2);
    push(K_ISSUE, 2'd0, 1'b0, 2);
    wait_until(W_ISSUE, "undef_issue");
    do_ex(1'b1);
    @(negedge clk) check("undef_done", 64'({bus_a.im_cs, bus_a.pc_ld, bus_a.pc_sel, bus_a.instr_count}), 64'({2'b10, 2'd2, 32'd3}));

    // asynchronous reset mid WAIT_EX
    bus_a.IR_out = 32'h0000_0020;
    push(K_IRLD, 2'd0, 1'b0, 3);
    push(K_ISSUE, 2'd0, 1'b0, 3);
    wait_until(W_ISSUE, "async_issue");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 64'({outs_a(), bus_a.instr_count}), 64'd0);
    repeat (2) @(negedge clk);
    check("async_held", 64'({outs_a(), bus_a.instr_count}), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
